uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bit count, legal values 1 or 2.
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, minimum 2.
REQ-006 SHALL provide port i_clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 SHALL provide port i_rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL provide port i_data, input, 8 bits, byte to transmit.
REQ-009 SHALL provide port i_valid, input, 1 bit, i_data valid this cycle.
REQ-010 SHALL provide port o_ready, output, 1 bit, FIFO can accept a byte this cycle.
REQ-011 SHALL provide port o_tx, output, 1 bit, serial line; idle high, registered.
REQ-012 SHALL provide port o_busy, output, 1 bit, high while a frame is on the line or the FIFO is non-empty.
REQ-013 SHALL provide port o_fifo_cnt, output, clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-014 SHALL set bit period BIT_CYC = CLK_FREQ/BAUD using integer truncation (434 at defaults); every line bit SHALL last exactly BIT_CYC cycles.
REQ-015 SHALL write i_data into the FIFO on any rising edge where i_valid and o_ready are both high; o_ready = (o_fifo_cnt < FIFO_DEPTH), combinational from registered count.
REQ-016 SHALL ignore i_valid while o_ready is low; the offered byte is dropped, not queued, and the count is unchanged.
REQ-017 SHALL run an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: o_tx=1; on the first edge with FIFO non-empty, SHALL pop the head byte into a shift register, go to START, and drive o_tx=0 from that edge.
REQ-019 START: one bit period, then go to DATA.
REQ-020 DATA: SHALL send 8 bits LSB first with a 3-bit index, then go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY: SHALL send ^byte for even and ~^byte for odd, for one bit period, then go to STOP.
REQ-022 STOP: o_tx=1 for STOP_BITS bit periods; at the end, if the FIFO is non-empty, SHALL pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-023 Frame length SHALL be (10 + (PARITY!=0) + (STOP_BITS-1)) * BIT_CYC cycles; 4340 cycles at defaults.
REQ-024 Latency: write at edge N into an empty FIFO with the FSM in IDLE SHALL give o_tx=0 after edge N+1.
REQ-025 A simultaneous push and pop SHALL leave o_fifo_cnt unchanged and preserve FIFO order; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Byte order on the line SHALL equal acceptance order; no byte is duplicated or skipped.
REQ-027 o_busy SHALL be low only in IDLE with o_fifo_cnt == 0.

Reset
REQ-028 While i_rst is high, asynchronously and regardless of state: o_tx=1, o_busy=0, o_fifo_cnt=0, FSM=IDLE, pointers, bit counter and baud counter all 0, o_ready=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame (line returns high immediately) and discard all FIFO contents; after release, no partial frame SHALL resume.

Verification
REQ-030 Defaults: single write of 0x28 -> line shows 0, bits 0,0,0,1,0,1,0,0, then 1, each 434 cycles; o_busy low 4340 cycles after start.
REQ-031 PARITY=1: send 0x73 -> parity bit 1; PARITY=2: send 0x73 -> parity bit 0; frame length 4774 cycles.
REQ-032 Write 0x28, 0x73, 0x55, 0x43 back-to-back -> four contiguous frames with no idle gap, decoded by a bench receiver model in the same order.
REQ-033 Hold i_valid high with FIFO_DEPTH+2 distinct bytes while line is busy -> o_ready drops at count 4, excess bytes dropped, and exactly the accepted bytes transmit.
REQ-034 STOP_BITS=2: send 0x55 then 0xAA -> 868-cycle high between the last data bit of 0x55 and the start bit of 0xAA.
REQ-035 Assert i_rst during the DATA bit 3 of 0x43 with 2 bytes queued -> o_tx=1 immediately, o_fifo_cnt=0; after release the line stays idle until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: bytes are queued on a valid/ready handshake
// and sent back-to-back as 8-bit LSB-first frames with optional parity and 1-2 stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] cnt_reg;

    state_t        state_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic          stop_idx_reg;
    logic [7:0]    shift_reg;
    logic          par_reg;
    logic          tx_reg;

    logic          push, pop, baud_done, last_stop, fifo_empty;
    logic [7:0]    head;

    assign fifo_empty = (cnt_reg == '0);
    assign o_ready    = (cnt_reg < CW'(FIFO_DEPTH));
    assign push       = i_valid && o_ready;
    assign head       = mem[rd_ptr_reg];
    assign baud_done  = (baud_cnt_reg == BW'(BIT_CYC - 1));
    assign last_stop  = (STOP_BITS == 2) ? stop_idx_reg : 1'b1;
    // Pop either to start from idle or to chain the next frame straight off the last stop bit.
    assign pop        = !fifo_empty &&
                        ((state_reg == ST_IDLE) ||
                         (state_reg == ST_STOP && baud_done && last_stop));

    assign o_tx       = tx_reg;
    assign o_busy     = !((state_reg == ST_IDLE) && fifo_empty);
    assign o_fifo_cnt = cnt_reg;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg    <= head;
                        par_reg      <= (PARITY == 2) ? ~^head : ^head;
                        tx_reg       <= 1'b0;
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            if (PARITY != 0) begin
                                tx_reg    <= par_reg;
                                state_reg <= ST_PARITY;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (!last_stop) begin
                            stop_idx_reg <= 1'b1;
                        end else if (pop) begin
                            shift_reg <= head;
                            par_reg   <= (PARITY == 2) ? ~^head : ^head;
                            tx_reg    <= 1'b0;
                            state_reg <= ST_START;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five parameter sets, a per-instance line receiver that checks
// every cycle of each frame against a scoreboard of accepted bytes, plus directed sequences.
module tb_uart_tx_fifo;

    localparam int NI = 5;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [NI];
    logic [7:0] data  [NI];
    logic       valid [NI];
    logic       ready [NI];
    logic       tx    [NI];
    logic       busy  [NI];
    logic [2:0] cnt   [NI];
    logic       lp    [NI];
    int         rxc   [NI];

    int checks = 0;
    int errors = 0;
    logic [7:0] bq [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        // 0: defaults; 1: 10-cycle bits; 2: even parity; 3: odd parity; 4: two stop bits
        localparam int CF = (gi == 0) ? 50_000_000 : 1_000_000;
        localparam int BR = (gi == 0) ? 115200 : 100_000;
        localparam int PM = (gi == 2) ? 1 : ((gi == 3) ? 2 : 0);
        localparam int SB = (gi == 4) ? 2 : 1;
        localparam int B  = CF / BR;
        localparam int NB = 10 + ((PM != 0) ? 1 : 0) + SB - 1;

        logic [7:0]  exp_q [$];
        logic        active = 1'b0;
        int          cyc = 0, idle_run = 0, hi_run = 0, last_hi = 0, rx_n = 0, j = 0;
        logic [11:0] fb = '1;
        logic [7:0]  exp_b = '0, got_b = '0;
        logic        bad = 1'b0, par_s = 1'b0;
        logic [7:0]  rx_mem  [64];
        int          gap_mem [64];

        assign lp[gi]  = par_s;
        assign rxc[gi] = rx_n;

        uart_tx_fifo #(
            .CLK_FREQ(CF), .BAUD(BR), .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(4)
        ) dut (
            .i_clk(clk), .i_rst(rst[gi]), .i_data(data[gi]), .i_valid(valid[gi]),
            .o_ready(ready[gi]), .o_tx(tx[gi]), .o_busy(busy[gi]), .o_fifo_cnt(cnt[gi])
        );

        always @(posedge clk) begin
            if (!rst[gi] && valid[gi] && ready[gi]) exp_q.push_back(data[gi]);
        end

        always @(negedge clk) begin
            if (rst[gi]) begin
                active = 1'b0; idle_run = 0; hi_run = 0;
                exp_q.delete();
            end else begin
                if (!active && tx[gi] == 1'b0) begin
                    active = 1'b1; cyc = 0; bad = 1'b0; got_b = '0;
                    last_hi = hi_run;
                    gap_mem[rx_n % 64] = idle_run;
                    check($sformatf("sb_nonempty_%0d", gi), (exp_q.size() != 0), 1);
                    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                    fb = '1; fb[0] = 1'b0; fb[8:1] = exp_b;
                    if (PM == 1) fb[9] = ^exp_b;
                    else if (PM == 2) fb[9] = ~^exp_b;
                end
                if (tx[gi]) hi_run++; else hi_run = 0;
                if (!active) begin
                    if (tx[gi]) idle_run++;
                end else begin
                    if (tx[gi] !== fb[cyc / B]) bad = 1'b1;
                    if (cyc % B == B / 2) begin
                        j = cyc / B;
                        if (j >= 1 && j <= 8) got_b[j-1] = tx[gi];
                        if (PM != 0 && j == 9) par_s = tx[gi];
                    end
                    if (cyc == NB * B - 1) begin
                        $display("rx[%0d] frame %0d byte 0x%02h (expected 0x%02h)", gi, rx_n, got_b, exp_b);
                        check($sformatf("rx_byte_%0d", gi), got_b, exp_b);
                        check($sformatf("waveform_%0d", gi), bad, 0);
                        rx_mem[rx_n % 64] = got_b;
                        rx_n++;
                        active = 1'b0; idle_run = 0;
                    end else begin
                        cyc++;
                    end
                end
            end
        end
    end

    task automatic put(input int k, input logic [7:0] d);
        @(negedge clk); data[k] = d; valid[k] = 1'b1;
        @(negedge clk); valid[k] = 1'b0;
    endtask

    task automatic put_burst(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); data[k] = bq[i]; valid[k] = 1'b1;
        end
        @(negedge clk); valid[k] = 1'b0;
    endtask

    task automatic wait_tx_low(input int k, input int limit);
        int n = 0;
        while (tx[k] !== 1'b0 && n < limit) begin
            @(negedge clk); n++;
        end
        if (tx[k] !== 1'b0) check("tx_start_timeout", tx[k], 0);
    endtask

    task automatic measure(input int k, output int len);
        len = 0;
        wait_tx_low(k, 100);
        while (busy[k] !== 1'b0 && len < 20000) begin
            @(negedge clk); len++;
        end
    endtask

    task automatic wait_idle(input int k, input int limit);
        int n = 0;
        while ((busy[k] !== 1'b0 || tx[k] !== 1'b1) && n < limit) begin
            @(negedge clk); n++;
        end
        if (busy[k] !== 1'b0) check("idle_timeout", busy[k], 0);
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        int         len;
        logic       chk_par;
        logic       par;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int len, base, lows;
        tbl[0] = '{1, 8'h28, 100, 1'b0, 1'b0};
        tbl[1] = '{1, 8'hFF, 100, 1'b0, 1'b0};
        tbl[2] = '{2, 8'h73, 110, 1'b1, 1'b1};
        tbl[3] = '{3, 8'h73, 110, 1'b1, 1'b0};
        tbl[4] = '{2, 8'h00, 110, 1'b1, 1'b0};
        tbl[5] = '{3, 8'h00, 110, 1'b1, 1'b1};
        tbl[6] = '{4, 8'h55, 110, 1'b0, 1'b0};

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; data[k] = 8'h00; valid[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_tx_%0d", k), tx[k], 1);
            check($sformatf("rst_busy_%0d", k), busy[k], 0);
            check($sformatf("rst_cnt_%0d", k), cnt[k], 0);
            check($sformatf("rst_ready_%0d", k), ready[k], 1);
            rst[k] = 1'b0;
        end

        // Default rate: 0x28 frame, busy falls exactly 4340 cycles after the start bit
        put(0, 8'h28);
        measure(0, len);
        check("default_frame_len", len, 4340);
        check("default_rx_count", rxc[0], 1);

        // Write-to-line latency: low after the edge following the write edge
        @(negedge clk); data[1] = 8'h3C; valid[1] = 1'b1;
        @(negedge clk); valid[1] = 1'b0;
        check("latency_tx_after_write_edge", tx[1], 1);
        check("latency_cnt", cnt[1], 1);
        @(negedge clk);
        check("latency_tx_low", tx[1], 0);
        wait_idle(1, 500);

        for (int r = 0; r < 7; r++) begin
            base = rxc[tbl[r].k];
            put(tbl[r].k, tbl[r].d);
            measure(tbl[r].k, len);
            $display("vec %0d inst %0d data 0x%02h len %0d", r, tbl[r].k, tbl[r].d, len);
            check($sformatf("vec%0d_len", r), len, tbl[r].len);
            if (tbl[r].chk_par) check($sformatf("vec%0d_parity", r), lp[tbl[r].k], tbl[r].par);
            check($sformatf("vec%0d_rx_count", r), rxc[tbl[r].k], base + 1);
        end

        // Back-to-back burst: contiguous frames in order
        base = rxc[1];
        bq[0] = 8'h28; bq[1] = 8'h73; bq[2] = 8'h55; bq[3] = 8'h43;
        put_burst(1, 4);
        wait_idle(1, 1000);
        check("burst_rx_count", rxc[1], base + 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_order_%0d", i), g_inst[1].rx_mem[(base + i) % 64], bq[i]);
            if (i > 0) check($sformatf("burst_gap_%0d", i), g_inst[1].gap_mem[(base + i) % 64], 0);
        end

        // Overflow: offer six bytes while a frame is on the line; only four fit
        base = rxc[1];
        put(1, 8'h11);
        wait_tx_low(1, 10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("ovf_ready_%0d", i), ready[1], (i < 4) ? 1 : 0);
            data[1] = 8'hA0 + 8'(i); valid[1] = 1'b1;
        end
        @(negedge clk); valid[1] = 1'b0;
        check("ovf_cnt_full", cnt[1], 4);
        check("ovf_ready_low", ready[1], 0);
        wait_idle(1, 1000);
        check("ovf_rx_count", rxc[1], base + 5);
        bq[0] = 8'h11; bq[1] = 8'hA0; bq[2] = 8'hA1; bq[3] = 8'hA2; bq[4] = 8'hA3;
        for (int i = 0; i < 5; i++)
            check($sformatf("ovf_order_%0d", i), g_inst[1].rx_mem[(base + i) % 64], bq[i]);

        // Two stop bits: 20-cycle high run between 0x55's last data bit and 0xAA's start
        base = rxc[4];
        bq[0] = 8'h55; bq[1] = 8'hAA;
        put_burst(4, 2);
        wait_idle(4, 1000);
        check("stop2_rx_count", rxc[4], base + 2);
        check("stop2_byte0", g_inst[4].rx_mem[base % 64], 8'h55);
        check("stop2_byte1", g_inst[4].rx_mem[(base + 1) % 64], 8'hAA);
        check("stop2_high_run", g_inst[4].last_hi, 20);

        // Reset during data bit 3 of 0x43 with two bytes queued
        base = rxc[1];
        bq[0] = 8'h43; bq[1] = 8'h11; bq[2] = 8'h22;
        put_burst(1, 3);
        len = 0;
        do begin
            @(negedge clk); #1; len++;
        end while (!(g_inst[1].active && g_inst[1].cyc == 43) && len < 300);
        check("rstmid_reached_bit3", g_inst[1].cyc, 43);
        check("rstmid_cnt_before", cnt[1], 2);
        check("rstmid_tx_before", tx[1], 0);
        rst[1] = 1'b1;
        #1;
        check("rstmid_tx", tx[1], 1);
        check("rstmid_cnt", cnt[1], 0);
        check("rstmid_busy", busy[1], 0);
        check("rstmid_ready", ready[1], 1);
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        lows = 0;
        repeat (330) begin
            @(negedge clk);
            if (tx[1] !== 1'b1) lows++;
        end
        check("rstmid_line_idle", lows, 0);
        check("rstmid_no_frames", rxc[1], base);
        check("rstmid_busy_after", busy[1], 0);
        put(1, 8'h5A);
        wait_idle(1, 500);
        check("rstmid_recover_count", rxc[1], base + 1);
        check("rstmid_recover_byte", g_inst[1].rx_mem[base % 64], 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
